// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit: a 12-state sequencer that latches the opcode in DECODE
// and decodes datapath controls combinationally from the current state.
module mc_control_fsm #(
   parameter logic [5:0] OP_R    = 6'b000000,
   parameter logic [5:0] OP_LW   = 6'b100011,
   parameter logic [5:0] OP_SW   = 6'b101011,
   parameter logic [5:0] OP_BEQ  = 6'b000100,
   parameter logic [5:0] OP_J    = 6'b000010,
   parameter logic [5:0] OP_ADDI = 6'b001000,
   parameter logic [5:0] OP_SLTI = 6'b001010
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       jr_control,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUOp1,
   output logic       ALUOp0,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [3:0] state,
   output logic       instr_done
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB   = 4'd7,
      S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IMMEX  = 4'd10, S_IMMWB = 4'd11
   } state_t;

   state_t     state_q, state_d, dec_st;
   logic [5:0] op_q;
   logic [1:0] alu_op;
   logic       op_legal;

   assign op_legal = opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SLTI};

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            if (opcode == OP_LW || opcode == OP_SW)          state_d = S_MEMADR;
            else if (opcode == OP_R)                         state_d = S_EXEC;
            else if (opcode == OP_BEQ)                       state_d = S_BRANCH;
            else if (opcode == OP_J)                         state_d = S_JUMP;
            else if (opcode == OP_ADDI || opcode == OP_SLTI) state_d = S_IMMEX;
            else                                             state_d = S_FETCH;
         end
         S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXEC:   state_d = jr_control ? S_FETCH : S_RWB;
         S_IMMEX:  state_d = S_IMMWB;
         default:  state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         op_q    <= 6'b000000;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) op_q <= opcode;
      end
   end

   // Under reset the non-enable controls show their FETCH values; enables are cleared below.
   assign dec_st = reset ? S_FETCH : state_q;

   always_comb begin
      PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemRead = 1'b0;
      MemWrite = 1'b0; MemtoReg = 1'b0; IRWrite = 1'b0; ALUSrcA = 1'b0;
      RegWrite = 1'b0; RegDst = 1'b0; alu_op = 2'b00; ALUSrcB = 2'd0;
      PCSource = 2'd0; instr_done = 1'b0;
      case (dec_st)
         S_FETCH: begin
            MemRead = 1'b1; IRWrite = 1'b1; PCWrite = 1'b1; ALUSrcB = 2'd1;
         end
         S_DECODE: begin
            ALUSrcB    = 2'd3;
            instr_done = !op_legal;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1; ALUSrcB = 2'd2;
         end
         S_MEMRD: begin
            MemRead = 1'b1; IorD = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1; MemtoReg = 1'b1; instr_done = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1; IorD = 1'b1; instr_done = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1; alu_op = 2'b10;
            if (jr_control) begin
               PCWrite = 1'b1; PCSource = 2'd3; instr_done = 1'b1;
            end
         end
         S_RWB: begin
            RegWrite = 1'b1; RegDst = 1'b1; instr_done = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = 1'b1; alu_op = 2'b01; PCWriteCond = 1'b1;
            PCSource = 2'd1; instr_done = 1'b1;
         end
         S_JUMP: begin
            PCWrite = 1'b1; PCSource = 2'd2; instr_done = 1'b1;
         end
         S_IMMEX: begin
            ALUSrcA = 1'b1; ALUSrcB = 2'd2;
            alu_op  = (op_q == OP_SLTI) ? 2'b11 : 2'b00;
         end
         S_IMMWB: begin
            RegWrite = 1'b1; instr_done = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         PCWrite = 1'b0; PCWriteCond = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
         IRWrite = 1'b0; RegWrite = 1'b0; instr_done = 1'b0;
      end
   end

   assign ALUOp1 = alu_op[1];
   assign ALUOp0 = alu_op[0];
   assign state  = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Cycle-by-cycle check of state and every control output against hand-written
// per-state control words, through a scoreboard queue.
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       jr_control;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
   logic       ALUSrcA, RegWrite, RegDst, ALUOp1, ALUOp0, instr_done;
   logic [1:0] ALUSrcB, PCSource;
   logic [3:0] state;

   mc_control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .jr_control(jr_control),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
      .RegWrite(RegWrite), .RegDst(RegDst), .ALUOp1(ALUOp1), .ALUOp0(ALUOp0),
      .ALUSrcB(ALUSrcB), .PCSource(PCSource), .state(state), .instr_done(instr_done)
   );

   always #5 clk = ~clk;

   // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,
   //  ALUOp1,ALUOp0, ALUSrcB[1:0], PCSource[1:0], instr_done}
   localparam logic [16:0] C_FETCH  = 17'b1001001000_00_01_00_0;
   localparam logic [16:0] C_DECODE = 17'b0000000000_00_11_00_0;
   localparam logic [16:0] C_DECILL = 17'b0000000000_00_11_00_1;
   localparam logic [16:0] C_MEMADR = 17'b0000000100_00_10_00_0;
   localparam logic [16:0] C_MEMRD  = 17'b0011000000_00_00_00_0;
   localparam logic [16:0] C_MEMWB  = 17'b0000010010_00_00_00_1;
   localparam logic [16:0] C_MEMWR  = 17'b0010100000_00_00_00_1;
   localparam logic [16:0] C_EXEC   = 17'b0000000100_10_00_00_0;
   localparam logic [16:0] C_EXECJR = 17'b1000000100_10_00_11_1;
   localparam logic [16:0] C_RWB    = 17'b0000000011_00_00_00_1;
   localparam logic [16:0] C_BRANCH = 17'b0100000100_01_00_01_1;
   localparam logic [16:0] C_JUMP   = 17'b1000000000_00_00_10_1;
   localparam logic [16:0] C_IMMADD = 17'b0000000100_00_10_00_0;
   localparam logic [16:0] C_IMMSLT = 17'b0000000100_11_10_00_0;
   localparam logic [16:0] C_IMMWB  = 17'b0000000010_00_00_00_1;
   localparam logic [16:0] C_RST    = 17'b0000000000_00_01_00_0;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
   localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000, SLTI = 6'b001010, ILL = 6'b111111;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic        jr;
      logic [3:0]  st;
      logic [16:0] ctl;
      string       name;
   } vec_t;

   typedef struct {
      logic [20:0] word;
      string       name;
   } exp_t;

   vec_t  vecs[$];
   exp_t  sb[$];
   int    checks = 0;
   int    errors = 0;
   logic [16:0] ctl_act;

   assign ctl_act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                     ALUSrcA, RegWrite, RegDst, ALUOp1, ALUOp0, ALUSrcB, PCSource, instr_done};

   task automatic add(input logic r, input logic [5:0] o, input logic j,
                      input logic [3:0] s, input logic [16:0] c, input string n);
      vec_t v;
      v.rst = r; v.op = o; v.jr = j; v.st = s; v.ctl = c; v.name = n;
      vecs.push_back(v);
   endtask

   // One cycle: drive at negedge, queue the expectation, sample mid-low-phase.
   task automatic step(input logic r, input logic [5:0] o, input logic j,
                       input logic [3:0] s, input logic [16:0] c, input string n);
      exp_t e;
      exp_t got;
      @(negedge clk);
      reset = r; opcode = o; jr_control = j;
      e.word = {s, c}; e.name = n;
      sb.push_back(e);
      #2;
      got = sb.pop_front();
      checks++;
      if ({state, ctl_act} !== got.word) begin
         errors++;
         $display("FAIL %s: got state=%0d ctl=%05h, want state=%0d ctl=%05h",
                  got.name, state, ctl_act, got.word[20:17], got.word[16:0]);
      end else begin
         $display("ok   %s: state=%0d ctl=%05h", got.name, state, ctl_act);
      end
   endtask

   initial begin
      reset = 1'b1; opcode = 6'b0; jr_control = 1'b0;

      add(1, LW,  0, 0, C_RST,    "reset_hold");
      add(0, LW,  0, 0, C_FETCH,  "lw_fetch");
      add(0, LW,  0, 1, C_DECODE, "lw_decode");
      add(0, LW,  0, 2, C_MEMADR, "lw_memadr");
      add(0, LW,  0, 3, C_MEMRD,  "lw_memrd");
      add(0, LW,  0, 4, C_MEMWB,  "lw_memwb");
      add(0, SW,  0, 0, C_FETCH,  "sw_fetch");
      add(0, SW,  0, 1, C_DECODE, "sw_decode");
      add(0, SW,  0, 2, C_MEMADR, "sw_memadr");
      add(0, SW,  1, 5, C_MEMWR,  "sw_memwr_jr_ignored");
      add(0, BEQ, 0, 0, C_FETCH,  "beq_fetch");
      add(0, BEQ, 0, 1, C_DECODE, "beq_decode");
      add(0, BEQ, 0, 8, C_BRANCH, "beq_branch");
      add(0, JMP, 0, 0, C_FETCH,  "j_fetch");
      add(0, JMP, 0, 1, C_DECODE, "j_decode");
      add(0, JMP, 0, 9, C_JUMP,   "j_jump");
      add(0, RT,  0, 0, C_FETCH,  "r_fetch");
      add(0, RT,  0, 1, C_DECODE, "r_decode");
      add(0, RT,  0, 6, C_EXEC,   "r_exec");
      add(0, RT,  1, 7, C_RWB,    "r_rwb_jr_ignored");
      add(0, RT,  1, 0, C_FETCH,  "jr_fetch_jr_ignored");
      add(0, RT,  1, 1, C_DECODE, "jr_decode");
      add(0, RT,  1, 6, C_EXECJR, "jr_exec");
      add(0, SLTI,0, 0, C_FETCH,  "slti_fetch");
      add(0, SLTI,0, 1, C_DECODE, "slti_decode");
      add(0, SLTI,0, 10,C_IMMSLT, "slti_immex");
      add(0, SLTI,0, 11,C_IMMWB,  "slti_immwb");
      add(0, ADDI,0, 0, C_FETCH,  "addi_fetch");
      add(0, ADDI,0, 1, C_DECODE, "addi_decode");
      add(0, SLTI,0, 10,C_IMMADD, "addi_immex_uses_latched_op");
      add(0, ADDI,0, 11,C_IMMWB,  "addi_immwb");
      add(0, ILL, 0, 0, C_FETCH,  "ill_fetch");
      add(0, ILL, 0, 1, C_DECILL, "ill_decode");
      add(0, ILL, 0, 0, C_FETCH,  "ill_back_to_fetch");

      @(negedge clk);
      @(negedge clk);

      foreach (vecs[i])
         step(vecs[i].rst, vecs[i].op, vecs[i].jr, vecs[i].st, vecs[i].ctl, vecs[i].name);

      // Opcode changes after DECODE: the latched LW still selects MEMRD.
      step(0, LW, 0, 1, C_DECODE, "opchg_decode");
      step(0, RT, 0, 2, C_MEMADR, "opchg_memadr");
      step(0, RT, 0, 3, C_MEMRD,  "opchg_memrd");
      step(0, RT, 0, 4, C_MEMWB,  "opchg_memwb");

      // Reset mid-LW in MEMRD aborts the instruction.
      step(0, LW, 0, 0, C_FETCH,  "rst_lw_fetch");
      step(0, LW, 0, 1, C_DECODE, "rst_lw_decode");
      step(0, LW, 0, 2, C_MEMADR, "rst_lw_memadr");
      step(1, LW, 0, 3, C_RST,    "rst_in_memrd");
      step(1, LW, 0, 0, C_RST,    "rst_held_fetch");
      step(0, LW, 0, 0, C_FETCH,  "rst_release_fetch");
      step(0, LW, 0, 1, C_DECODE, "rst_release_decode");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
